// File: rtl/led_pkg.sv
// Shared definitions for the LED display arbiter: controller states and default sizing.
package led_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_STEP  = 10;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_LENW  = 8;

endpackage

// File: rtl/rr_arb.sv
// Round-robin selector: picks the first requester at or above ptr, wrapping around.
module rr_arb #(
    parameter int NREQ = 4,
    parameter int IDXW = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    input  logic            valid_en,
    output logic [NREQ-1:0] gnt,
    output logic [IDXW-1:0] gnt_idx
);

    logic            found;
    logic [IDXW-1:0] idx;

    // Walk the requesters starting at ptr and grant the first active one.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = IDXW'((int'(ptr) + i) % NREQ);
            if (valid_en && !found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/led_arb.sv
// LED display arbiter: grants one requester at a time and shows its pattern
// for len*STEP cycles, followed by a one-cycle blank gap with a done pulse.
module led_arb
    import led_pkg::*;
#(
    parameter int STEP  = DEF_STEP,
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int LENW  = DEF_LENW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*WIDTH-1:0]    req_pattern,
    input  logic [NREQ*LENW-1:0]     req_len,
    output logic [WIDTH-1:0]         led_out,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     busy,
    output logic                     done
);

    localparam int IDXW = $clog2(NREQ);
    localparam int PW   = (STEP > 1) ? $clog2(STEP) : 1;

    state_t            state;
    logic [IDXW-1:0]   ptr;
    logic [PW-1:0]     pre;
    logic [LENW-1:0]   steps;
    logic [NREQ-1:0]   gnt;
    logic [IDXW-1:0]   gnt_idx;
    logic              valid_en;
    logic              any_gnt;
    logic [WIDTH-1:0]  sel_pattern;
    logic [LENW-1:0]   sel_len;

    // Grants are only offered while idle; reset masks them immediately.
    assign valid_en  = (state == IDLE) && !rst;
    assign any_gnt   = |gnt;
    assign req_ready = gnt;

    rr_arb #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr_arb (
        .req      (req_valid),
        .ptr      (ptr),
        .valid_en (valid_en),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx)
    );

    // One-hot mux of the granted requester's pattern and length.
    always_comb begin
        sel_pattern = '0;
        sel_len     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_pattern = req_pattern[i*WIDTH +: WIDTH];
                sel_len     = req_len[i*LENW +: LENW];
            end
        end
    end

    // Controller: capture on grant, count len steps of STEP cycles, then blank gap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            led_out  <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ptr      <= '0;
            pre      <= '0;
            steps    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (any_gnt) begin
                        grant_id <= gnt_idx;
                        ptr      <= (gnt_idx == IDXW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                        pre      <= '0;
                        steps    <= sel_len;
                        busy     <= 1'b1;
                        if (sel_len != '0) begin
                            state   <= SHOW;
                            led_out <= sel_pattern;
                        end else begin
                            state   <= GAP;
                            led_out <= '0;
                            done    <= 1'b1;
                        end
                    end
                end
                SHOW: begin
                    if (pre == PW'(STEP - 1)) begin
                        pre <= '0;
                        if (steps == LENW'(1)) begin
                            state   <= GAP;
                            led_out <= '0;
                            done    <= 1'b1;
                            steps   <= '0;
                        end else begin
                            steps <= steps - 1'b1;
                        end
                    end else begin
                        pre <= pre + 1'b1;
                    end
                end
                GAP: begin
                    state   <= IDLE;
                    led_out <= '0;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    led_out <= '0;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_arb.sv
// Testbench for led_arb: scoreboard of expected grants from a timing-level model,
// plus directed reset, drop-out and long-show scenarios.
module tb_led_arb;

    localparam int TB_STEP = 10;

    typedef struct {
        int         id;
        logic [7:0] pat;
        int         len;
        int         cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [31:0] req_pattern = '0;
    logic [31:0] req_len = '0;
    logic [7:0]  led_out;
    logic [1:0]  grant_id;
    logic        busy;
    logic        done;

    logic [3:0]  v1 = '0;
    logic [3:0]  ready1;
    logic [31:0] pat1 = '0;
    logic [31:0] len1 = '0;
    logic [7:0]  led1;
    logic [1:0]  gid1;
    logic        busy1;
    logic        done1;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   mon_en = 1'b1;
    exp_t exp_q[$];
    int   grant_ids[$];
    int   grant_cycs[$];
    int   m_ptr = 0;
    int   next_ok = 0;

    led_arb #(.STEP(TB_STEP), .NREQ(4), .WIDTH(8), .LENW(8)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_pattern (req_pattern),
        .req_len     (req_len),
        .led_out     (led_out),
        .grant_id    (grant_id),
        .busy        (busy),
        .done        (done)
    );

    led_arb #(.STEP(1), .NREQ(4), .WIDTH(8), .LENW(8)) u_dut1 (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (v1),
        .req_ready   (ready1),
        .req_pattern (pat1),
        .req_len     (len1),
        .led_out     (led1),
        .grant_id    (gid1),
        .busy        (busy1),
        .done        (done1)
    );

    always #5 clk = ~clk;

    // Free-running cycle index used to timestamp grants.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one cycle of requests; the model decides whether a grant is due now.
    task automatic applyStimulus(input logic [3:0] v, input logic [31:0] pats, input logic [31:0] lens);
        exp_t e;
        bit   found;
        int   g;
        req_valid   = v;
        req_pattern = pats;
        req_len     = lens;
        found = 1'b0;
        g = 0;
        if (cyc >= next_ok && v != 4'b0) begin
            for (int i = 0; i < 4; i++) begin
                if (!found && v[(m_ptr + i) % 4]) begin
                    found = 1'b1;
                    g = (m_ptr + i) % 4;
                end
            end
            e.id  = g;
            e.pat = pats[g*8 +: 8];
            e.len = int'(lens[g*8 +: 8]);
            e.cyc = cyc;
            exp_q.push_back(e);
            next_ok = cyc + e.len * TB_STEP + 2;
            m_ptr = (g + 1) % 4;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) applyStimulus(4'b0, $urandom, $urandom);
    endtask

    task automatic doReset();
        rst = 1'b1;
        req_valid = '0;
        exp_q.delete();
        grant_ids.delete();
        grant_cycs.delete();
        m_ptr = 0;
        next_ok = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: on every grant, pop the expected transaction and follow its display.
    initial begin
        exp_t e;
        int   seen;
        forever begin
            @(negedge clk);
            if (rst || !mon_en) continue;
            if (req_ready != 4'b0) begin
                seen = 0;
                for (int i = 0; i < 4; i++) if (req_ready[i]) seen = i;
                grant_ids.push_back(seen);
                grant_cycs.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_grant", int'(req_ready), 0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("grant_onehot", int'(req_ready), 1 << e.id);
                    checkOutput("grant_cycle", cyc, e.cyc);
                    for (int k = 0; k < e.len * TB_STEP; k++) begin
                        @(negedge clk);
                        checkOutput("show_led", int'(led_out), int'(e.pat));
                        checkOutput("show_busy", int'(busy), 1);
                        checkOutput("show_ready", int'(req_ready), 0);
                        checkOutput("show_done", int'(done), 0);
                        checkOutput("show_grant_id", int'(grant_id), e.id);
                    end
                    @(negedge clk);
                    checkOutput("gap_led", int'(led_out), 0);
                    checkOutput("gap_done", int'(done), 1);
                    checkOutput("gap_busy", int'(busy), 1);
                    checkOutput("gap_ready", int'(req_ready), 0);
                    checkOutput("gap_grant_id", int'(grant_id), e.id);
                end
            end else begin
                checkOutput("idle_led", int'(led_out), 0);
                checkOutput("idle_busy", int'(busy), 0);
                checkOutput("idle_done", int'(done), 0);
            end
        end
    end

    // Main sequence of scenarios.
    initial begin
        int exp_ord[5] = '{0, 1, 2, 3, 0};
        int first;
        int last;
        int cnt;
        int dcnt;
        int n1;

        doReset();
        #1;
        checkOutput("reset_led", int'(led_out), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_grant_id", int'(grant_id), 0);

        // Single requester 0, pattern A5 for three steps.
        applyStimulus(4'b0001, 32'h000000A5, 32'h00000003);
        idleCycles(40);
        checkOutput("s033_grants", grant_ids.size(), 1);
        if (grant_ids.size() > 0) checkOutput("s033_id", grant_ids[0], 0);

        // All four requesting continuously with len 1.
        doReset();
        for (int k = 0; k < 60; k++) applyStimulus(4'hF, $urandom, 32'h01010101);
        idleCycles(20);
        checkOutput("s034_grants", grant_ids.size(), 5);
        for (int k = 0; k < 5 && k < grant_ids.size(); k++) begin
            checkOutput("s034_order", grant_ids[k], exp_ord[k]);
            if (k > 0) checkOutput("s034_spacing", grant_cycs[k] - grant_cycs[k-1], 12);
        end

        // Zero-length request from requester 2; pointer then favours requester 3.
        doReset();
        applyStimulus(4'b0100, 32'h005A0000, 32'h00000000);
        applyStimulus(4'b0000, 32'h0, 32'h0);
        applyStimulus(4'b1111, $urandom, 32'h0);
        idleCycles(10);
        checkOutput("s035_grants", grant_ids.size(), 2);
        if (grant_ids.size() >= 2) begin
            checkOutput("s035_first", grant_ids[0], 2);
            checkOutput("s035_next", grant_ids[1], 3);
            checkOutput("s035_spacing", grant_cycs[1] - grant_cycs[0], 2);
        end

        // Requester 1 raises valid briefly during another show and then gives up.
        doReset();
        applyStimulus(4'b0001, 32'h00000081, 32'h00000002);
        idleCycles(3);
        applyStimulus(4'b0010, 32'h00000F00, 32'h00000100);
        applyStimulus(4'b0010, 32'h00000F00, 32'h00000100);
        idleCycles(30);
        n1 = 0;
        foreach (grant_ids[k]) if (grant_ids[k] == 1) n1++;
        checkOutput("s037_req1_grants", n1, 0);
        checkOutput("s037_grants", grant_ids.size(), 1);

        // Randomised traffic with valid dropping and inputs changing after transfer.
        doReset();
        for (int k = 0; k < 1500; k++) begin
            applyStimulus(4'($urandom_range(0, 15)), $urandom,
                          {8'($urandom_range(0, 4)), 8'($urandom_range(0, 4)),
                           8'($urandom_range(0, 4)), 8'($urandom_range(0, 4))});
        end
        idleCycles(50);
        checkOutput("random_pending", exp_q.size(), 0);

        // Asynchronous reset in the middle of a show.
        doReset();
        mon_en = 1'b0;
        req_valid = 4'b0100;
        req_pattern = 32'h00A50000;
        req_len = 32'h00030000;
        @(posedge clk);
        #1;
        req_valid = '0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checkOutput("s036_pre_led", int'(led_out), 'hA5);
        checkOutput("s036_pre_grant", int'(grant_id), 2);
        rst = 1'b1;
        #1;
        checkOutput("s036_led", int'(led_out), 0);
        checkOutput("s036_busy", int'(busy), 0);
        checkOutput("s036_grant_id", int'(grant_id), 0);
        checkOutput("s036_done", int'(done), 0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checkOutput("s036_done_held", int'(done), 0);
        end
        rst = 1'b0;
        req_valid = 4'b1010;
        req_len = 32'h0;
        #1;
        checkOutput("s036_first_ready", int'(req_ready), 'b0010);
        @(posedge clk);
        #1;
        req_valid = '0;
        repeat (4) @(posedge clk);
        #1;
        doReset();
        mon_en = 1'b1;

        // Long show on the STEP=1 instance: 255 steps of one cycle each.
        v1 = 4'b0001;
        pat1 = 32'h0000003C;
        len1 = 32'h000000FF;
        @(negedge clk);
        checkOutput("s038_ready", int'(ready1), 1);
        @(posedge clk);
        #1;
        v1 = '0;
        pat1 = 32'h0;
        len1 = 32'h0;
        first = -1;
        last = -1;
        cnt = 0;
        dcnt = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (led1 == 8'h3C) begin
                cnt++;
                if (first < 0) first = k;
                last = k;
            end
            if (done1) dcnt++;
        end
        checkOutput("s038_show_cycles", cnt, 255);
        checkOutput("s038_contiguous", last - first + 1, 255);
        checkOutput("s038_done_pulses", dcnt, 1);
        checkOutput("s038_busy_after", int'(busy1), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
